vio_route_tagger: RTL
=====================

// Module: vio_route_tagger
// PURPOSE
// - Per-region stage directly upstream of the vFPGA data switch.
// - Takes the user-logic DTU stream and binds each packet to one route word.
// - Drives that route onto the switch route_in lane and holds it stable for the whole packet.
// - Drops packets whose destination is out of range.
// - Full-throughput registered slice; one instance per region.
// PARAMETERS
// - AXI_DATA_BITS  512        tdata width; tkeep is AXI_DATA_BITS/8.
// - PID_BITS       6          tid width.
// - ROUTE_BITS     14         route word width, matches the switch tdest lane.
// - N_ID           N_REGIONS  region count; legal destinations are 0..2*N_ID-1.
// - CNT_BITS       32         statistics counter width.
// PORTS
// - aclk            in   1               clock
// - areset          in   1               reset; asynchronous, active-high
// - route_cfg       in   ROUTE_BITS      new route word from the control plane
// - route_cfg_valid in   1               1-cycle strobe that loads route_cfg
// - route_out       out  ROUTE_BITS      route for the current packet, to the switch route_in
// - s_tvalid/s_tready/s_tlast  in/out/in  1        user-side AXI4SR sink
// - s_tdata/s_tkeep/s_tid      in         D/D/8/PID_BITS
// - m_tvalid/m_tready/m_tlast  out/in/out 1        switch-side AXI4SR source
// - m_tdata/m_tkeep/m_tid      out        same widths as the sink
// - pkt_cnt         out  CNT_BITS        packets forwarded (counted on the tlast beat)
// - drop_cnt        out  CNT_BITS        packets dropped
// - busy            out  1               1 while a packet is mid-flight (state != IDLE)
// BEHAVIOUR
// - Reset:
//   - All outputs are 0; m_tvalid=0, s_tready=0.
//   - shadow=0, active=0, both counters 0, FSM=IDLE.
//   - s_tready rises on the first cycle after reset is released.
// - Config:
//   - When route_cfg_valid=1, shadow <= route_cfg.
//   - active <= shadow only in IDLE, when the first beat of a packet is accepted.
//   - If the strobe and a first beat land in the same cycle, active takes the new route_cfg (bypass).
//   - route_out = active. It never changes while busy=1 or m_tvalid=1.
// - Destination: dest = route[5:3].
//   - Legal when dest < 2*N_ID.
//   - Legal destinations are the dtu/host ports of the switch.
// - FSM states: IDLE, PASS, DROP.
//   - IDLE, first beat accepted, legal dest   -> PASS. The beat is forwarded.
//   - IDLE, first beat accepted, illegal dest -> DROP. The beat is discarded.
//   - If the first beat also has tlast=1, the state returns to IDLE at once and the packet is counted.
//   - PASS, tlast beat accepted -> IDLE; pkt_cnt++.
//   - DROP: s_tready=1 every cycle and nothing reaches m_*.
//   - DROP, tlast beat accepted -> IDLE; drop_cnt++.
// - Handshake:
//   - Two-entry skid buffer: output register plus skid register.
//   - Latency: 1 cycle from s accept to m_tvalid.
//   - Throughput: 1 beat/cycle when m_tready is held at 1.
//   - s_tready = !skid_full, and it is registered.
//   - m_tvalid must not drop until m_tready=1. m_* stay stable while stalled.
//   - tkeep, tid and tlast pass through unmodified.
// - Packet boundary:
//   - A new packet enters only after the previous tlast has left m_* (m_tvalid&m_tready&m_tlast).
//   - Until then, a first beat arriving in IDLE waits with s_tready=0.
//   - This guarantees route_out is stable per packet.
// - Counters: saturate at all-ones, no wrap.
// - Reset mid-packet:
//   - Everything is flushed immediately and the partial packet is lost.
//   - No counter increments for it.
// STRUCTURE
// - Shared package lynxTypes holds:
//   - ROUTE_BITS and the dest field position (ROUTE_DEST_LSB=3, ROUTE_DEST_W=3).
//   - typedef route_t.
// - Local enum for the FSM states.
// - One sub-module, vio_skid_buf: a generic 2-entry AXI4SR register slice with flush input.
// - Top level holds the FSM, route registers and counters.
// TESTING
// - Cfg 14'h0010 (dest 2), 4-beat packet, m_tready=1:
//   - 4 beats out back-to-back, first at cycle+1.
//   - route_out=14'h0010 throughout; pkt_cnt=1.
// - Cfg 14'h0038 (dest 7, N_ID=3), 3-beat packet:
//   - No m_tvalid; s_tready=1 on every beat.
//   - drop_cnt=1; route_out is unchanged.
// - Cfg strobe 14'h0008 on beat 2 of a packet routed with 14'h0010:
//   - route_out stays 14'h0010 until the tlast handshake.
//   - The next packet uses 14'h0008.
// - Random m_tready (50%), 100 packets of 1..16 beats:
//   - Data/keep/tid/tlast match scoreboard; no beat loss or duplication.
//   - pkt_cnt=100; route_out is stable whenever m_tvalid=1.
// - Single-beat packets every cycle with m_tready=1:
//   - Sustained throughput of 1 packet per 2 cycles (boundary wait); counts are exact.
// - areset pulsed on beat 2 of 5:
//   - All outputs 0 within the reset cycle.
//   - The next packet is forwarded cleanly; counters read 0/1 as expected.

Source files
------------

// File: rtl/vio_route_tagger_pkg.sv
// Shared routing types for the vFPGA region data path: route word layout and
// the destination-field helpers used by every per-region stage.
package lynxTypes;

    localparam int ROUTE_BITS     = 14;
    localparam int ROUTE_DEST_LSB = 3;
    localparam int ROUTE_DEST_W   = 3;

    typedef logic [ROUTE_BITS-1:0]   route_t;
    typedef logic [ROUTE_DEST_W-1:0] dest_t;

    function automatic dest_t route_dest(input route_t route);
        return route[ROUTE_DEST_LSB +: ROUTE_DEST_W];
    endfunction

    // Only the dtu/host ports of the switch (0 .. 2*nId-1) are reachable.
    function automatic logic dest_legal(input dest_t dest, input int nId);
        return (int'(dest) < 2 * nId);
    endfunction

endpackage

// File: rtl/vio_route_tagger_skid.sv
// Generic two-entry AXI-stream register slice (output register + skid register)
// with a registered ready and a synchronous flush.
module vio_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_flush,
    input  logic         i_s_valid,
    output logic         o_s_ready,
    input  logic [W-1:0] i_s_data,
    output logic         o_m_valid,
    input  logic         i_m_ready,
    output logic [W-1:0] o_m_data
);

    logic         r_mValid;
    logic         r_skValid;
    logic         r_ready;
    logic [W-1:0] r_mData;
    logic [W-1:0] r_skData;

    logic w_sFire;
    logic w_outFree;
    logic w_skNext;

    assign w_sFire   = i_s_valid & r_ready;
    assign w_outFree = ~r_mValid | i_m_ready;
    // Ready tracks the skid register, so a beat can never arrive while the skid is occupied.
    assign w_skNext  = w_outFree ? 1'b0 : (r_skValid | w_sFire);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mValid  <= 1'b0;
            r_skValid <= 1'b0;
            r_ready   <= 1'b0;
            r_mData   <= '0;
            r_skData  <= '0;
        end else if (i_flush) begin
            r_mValid  <= 1'b0;
            r_skValid <= 1'b0;
            r_ready   <= 1'b1;
        end else begin
            r_ready   <= ~w_skNext;
            r_skValid <= w_skNext;
            if (w_outFree) begin
                if (r_skValid) begin
                    r_mData  <= r_skData;
                    r_mValid <= 1'b1;
                end else begin
                    r_mValid <= w_sFire;
                    if (w_sFire) begin
                        r_mData <= i_s_data;
                    end
                end
            end else if (w_sFire) begin
                r_skData <= i_s_data;
            end
        end
    end

    assign o_s_ready = r_ready;
    assign o_m_valid = r_mValid;
    assign o_m_data  = r_mData;

endmodule

// File: rtl/vio_route_tagger.sv
// Per-region route tagger in front of the vFPGA switch: binds each packet to one
// route word, drops out-of-range destinations and keeps per-region statistics.
module vio_route_tagger
    import lynxTypes::*;
#(
    parameter int AXI_DATA_BITS = 512,
    parameter int PID_BITS      = 6,
    parameter int N_ID          = 3,
    parameter int CNT_BITS      = 32
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic [ROUTE_BITS-1:0]      route_cfg,
    input  logic                       route_cfg_valid,
    output logic [ROUTE_BITS-1:0]      route_out,
    input  logic                       s_tvalid,
    output logic                       s_tready,
    input  logic                       s_tlast,
    input  logic [AXI_DATA_BITS-1:0]   s_tdata,
    input  logic [AXI_DATA_BITS/8-1:0] s_tkeep,
    input  logic [PID_BITS-1:0]        s_tid,
    output logic                       m_tvalid,
    input  logic                       m_tready,
    output logic                       m_tlast,
    output logic [AXI_DATA_BITS-1:0]   m_tdata,
    output logic [AXI_DATA_BITS/8-1:0] m_tkeep,
    output logic [PID_BITS-1:0]        m_tid,
    output logic [CNT_BITS-1:0]        pkt_cnt,
    output logic [CNT_BITS-1:0]        drop_cnt,
    output logic                       busy
);

    localparam int KEEP_BITS = AXI_DATA_BITS / 8;
    localparam int PAY_W     = AXI_DATA_BITS + KEEP_BITS + PID_BITS + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PASS,
        ST_DROP
    } state_t;

    state_t              r_state;
    route_t              r_shadow;
    route_t              r_active;
    logic                r_pending;
    logic [CNT_BITS-1:0] r_pktCnt;
    logic [CNT_BITS-1:0] r_dropCnt;

    logic             w_bufReady;
    logic             w_sReady;
    logic             w_accept;
    logic             w_fwd;
    logic             w_legal;
    logic             w_mLastFire;
    route_t           w_newRoute;
    logic [PAY_W-1:0] w_inPay;
    logic [PAY_W-1:0] w_outPay;

    function automatic logic [CNT_BITS-1:0] satInc(input logic [CNT_BITS-1:0] v);
        return (v == '1) ? v : v + CNT_BITS'(1);
    endfunction

    // A strobe coinciding with a first beat must win, so the route is bypassed from the input.
    assign w_newRoute  = route_cfg_valid ? route_cfg : r_shadow;
    assign w_legal     = dest_legal(route_dest(w_newRoute), N_ID);
    assign w_accept    = s_tvalid & w_sReady;
    assign w_fwd       = w_accept & ((r_state == ST_PASS) | ((r_state == ST_IDLE) & w_legal));
    assign w_mLastFire = m_tvalid & m_tready & m_tlast;

    // r_pending holds off a new packet until the previous tlast has left the switch side.
    always_comb begin
        w_sReady = 1'b0;
        unique case (r_state)
            ST_IDLE: w_sReady = w_bufReady & ~r_pending;
            ST_PASS: w_sReady = w_bufReady;
            ST_DROP: w_sReady = 1'b1;
            default: w_sReady = 1'b0;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state   <= ST_IDLE;
            r_shadow  <= '0;
            r_active  <= '0;
            r_pending <= 1'b0;
            r_pktCnt  <= '0;
            r_dropCnt <= '0;
        end else begin
            if (route_cfg_valid) begin
                r_shadow <= route_cfg;
            end
            if (w_fwd & s_tlast) begin
                r_pending <= 1'b1;
            end else if (w_mLastFire) begin
                r_pending <= 1'b0;
            end
            unique case (r_state)
                ST_IDLE: begin
                    // Dropped packets leave the active route alone so route_out never shows a bad route.
                    if (w_accept) begin
                        if (w_legal) begin
                            r_active <= w_newRoute;
                            if (s_tlast) begin
                                r_pktCnt <= satInc(r_pktCnt);
                            end else begin
                                r_state <= ST_PASS;
                            end
                        end else begin
                            if (s_tlast) begin
                                r_dropCnt <= satInc(r_dropCnt);
                            end else begin
                                r_state <= ST_DROP;
                            end
                        end
                    end
                end
                ST_PASS: begin
                    if (w_accept & s_tlast) begin
                        r_state  <= ST_IDLE;
                        r_pktCnt <= satInc(r_pktCnt);
                    end
                end
                ST_DROP: begin
                    if (w_accept & s_tlast) begin
                        r_state   <= ST_IDLE;
                        r_dropCnt <= satInc(r_dropCnt);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_inPay = {s_tdata, s_tkeep, s_tid, s_tlast};

    // Asynchronous reset already clears the slice, so the flush input stays idle here.
    vio_skid_buf #(
        .W (PAY_W)
    ) u_skid (
        .clk       (aclk),
        .rst       (areset),
        .i_flush   (1'b0),
        .i_s_valid (w_fwd),
        .o_s_ready (w_bufReady),
        .i_s_data  (w_inPay),
        .o_m_valid (m_tvalid),
        .i_m_ready (m_tready),
        .o_m_data  (w_outPay)
    );

    assign {m_tdata, m_tkeep, m_tid, m_tlast} = w_outPay;

    assign s_tready  = w_sReady;
    assign route_out = r_active;
    assign pkt_cnt   = r_pktCnt;
    assign drop_cnt  = r_dropCnt;
    assign busy      = (r_state != ST_IDLE);

endmodule
